// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the PISO serial transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int frame_len(input int width, input bit parity);
        return width + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: load/clear/increment, saturating at LAST with a terminal-count flag.
module piso_bit_counter #(
    parameter int LAST = 7,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic          inc,
    input  logic [CW-1:0] load_value,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(LAST));

    // Bit index of the frame bit currently on the serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and framed serial output.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done
);

`ifdef PISO_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int FRAME_LEN = frame_len(WIDTH, PARITY);
    localparam int CW        = $clog2(FRAME_LEN + 1);

    piso_state_t          state;
    piso_state_t          next_state;
    logic [CW-1:0]        count;
    logic                 tc;
    logic                 accept;
    logic                 cnt_load;
    logic                 cnt_clear;
    logic                 cnt_inc;
    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-1:0] shreg;

    assign accept = load_valid && load_ready;

    // Arrange the incoming word in transmit order: frame[0] goes out first
    always_comb begin
        frame = '0;
        for (int i = 0; i < WIDTH; i++) begin
            frame[i] = LSB_FIRST ? load_data[i] : load_data[WIDTH-1-i];
        end
`ifdef PISO_PARITY_EN
        frame[FRAME_LEN-1] = ^load_data;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a word accepted in the last-bit cycle keeps us in SHIFT
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? SHIFT : IDLE;
            SHIFT:   next_state = (tc && !accept) ? IDLE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // Output and counter-control decode
    always_comb begin
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        cnt_load    = accept;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = !rst;
            end
            SHIFT: begin
                load_ready  = !rst && tc;
                ser_valid   = 1'b1;
                frame_start = (count == '0);
                frame_done  = tc;
                cnt_clear   = tc && !accept;
                cnt_inc     = !tc;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    piso_bit_counter #(
        .LAST (FRAME_LEN - 1),
        .CW   (CW)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .clear      (cnt_clear),
        .inc        (cnt_inc),
        .load_value ('0),
        .count      (count),
        .tc         (tc)
    );

    // Serial datapath: the first bit is launched straight from the load word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_out <= 1'b0;
            shreg   <= '0;
        end else if (accept) begin
            ser_out <= frame[0];
            shreg   <= frame >> 1;
        end else if (state == SHIFT && !tc) begin
            ser_out <= shreg[0];
            shreg   <= shreg >> 1;
        end else begin
            ser_out <= 1'b0;
            shreg   <= '0;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a queue-based frame model, plus literal frame checks.
module tb_piso_shift_tx;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = 8 + (PAR ? 1 : 0);

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv  = 1'b1;
    logic [7:0] ld  = 8'h5A;
    logic [1:0] ready, sout, svalid, fstart, fdone;

    int   total  = 0;
    int   passed = 0;
    ent_t q0[$];
    ent_t q1[$];
    logic acc_flag = 1'b0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready[0]), .load_data(ld),
        .ser_out(sout[0]), .ser_valid(svalid[0]), .frame_start(fstart[0]), .frame_done(fdone[0])
    );

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready[1]), .load_data(ld),
        .ser_out(sout[1]), .ser_valid(svalid[1]), .frame_start(fstart[1]), .frame_done(fdone[1])
    );

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    endtask

    task automatic check_v(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic frame_bit(input logic [7:0] w, input bit lsb, input int i);
        if (i >= 8) return ^w;
        return lsb ? w[i] : w[7-i];
    endfunction

    // Reference model: each queue holds the bits still to appear, head = bit on the line now
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            acc_flag = 1'b0;
        end else begin
            acc_flag = lv && (q0.size() <= 1);
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            if (acc_flag) begin
                for (int i = 0; i < FL; i++) begin
                    q0.push_back('{b: frame_bit(ld, 1'b1, i), first: (i == 0), last: (i == FL-1)});
                    q1.push_back('{b: frame_bit(ld, 1'b0, i), first: (i == 0), last: (i == FL-1)});
                end
            end
        end
    end

    task automatic cmp(input int j, input ent_t head, input int sz);
        logic v;
        v = (sz > 0);
        check($sformatf("ser_valid[%0d]", j), svalid[j], v);
        check($sformatf("ser_out[%0d]", j), sout[j], v ? head.b : 1'b0);
        check($sformatf("frame_start[%0d]", j), fstart[j], v ? head.first : 1'b0);
        check($sformatf("frame_done[%0d]", j), fdone[j], v ? head.last : 1'b0);
        check($sformatf("load_ready[%0d]", j), ready[j], !rst && (sz <= 1));
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        #1;
        cmp(0, (q0.size() > 0) ? q0[0] : ent_t'(3'b000), q0.size());
        cmp(1, (q1.size() > 0) ? q1[0] : ent_t'(3'b000), q1.size());
    end

    task automatic send(input logic [7:0] w);
        int n;
        @(negedge clk);
        lv = 1'b1;
        ld = w;
        n  = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_flag && n < 50);
        if (!acc_flag) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic collect(output logic [15:0] b0, output logic [15:0] b1, output logic fl_ok);
        b0 = '0;
        b1 = '0;
        fl_ok = 1'b1;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            #1;
            lv = 1'b0;
            b0[i] = sout[0];
            b1[i] = sout[1];
            fl_ok &= svalid[0] && (fstart[0] == (i == 0)) && (fdone[0] == (i == FL-1));
        end
        @(negedge clk);
        #1;
        check("post_frame_idle", svalid[0] | svalid[1], 1'b0);
    endtask

    initial begin
        logic [15:0] b0, b1;
        logic        ok;
        int          nv;

        // Reset with load_valid high
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", ready[0] | ready[1], 1'b0);
        check("rst_valid", svalid[0] | svalid[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lv  = 1'b0;
        #1;
        check("ready_after_rst", ready[0] & ready[1], 1'b1);

        // Single words, literal expectations
        send(8'hA5);
        collect(b0, b1, ok);
        check_v("a5_lsb_bits", b0, 16'h00A5);
        check_v("a5_msb_bits", b1, 16'h00A5);
        check("a5_framing", ok, 1'b1);

        send(8'h80);
        collect(b0, b1, ok);
        check_v("h80_lsb_bits", b0, 16'h0080 | (PAR ? 16'h0100 : 16'h0000));
        check_v("h80_msb_bits", b1, 16'h0001 | (PAR ? 16'h0100 : 16'h0000));

        send(8'h07);
        collect(b0, b1, ok);
        check_v("h07_lsb_bits", b0, 16'h0007 | (PAR ? 16'h0100 : 16'h0000));
        send(8'h03);
        collect(b0, b1, ok);
        check_v("h03_lsb_bits", b0, 16'h0003);
        check("h03_framing", ok, 1'b1);

        // Back-to-back with load_valid held
        send(8'h0F);
        @(negedge clk);
        ld = 8'hF0;
        nv = 0;
        do begin
            @(posedge clk);
            #1;
            nv++;
        end while (!acc_flag && nv < 50);
        check("b2b_second_accept", acc_flag, 1'b1);
        check("b2b_no_gap_start", fstart[0] & svalid[0], 1'b1);
        @(negedge clk);
        lv = 1'b0;
        repeat (FL + 2) @(negedge clk);

        // Reset during bit 4 of 8'hFF
        send(8'hFF);
        @(negedge clk);
        lv = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid_drop", svalid[0] | svalid[1], 1'b0);
        check("midrst_out_drop", sout[0] | sout[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (FL + 2) begin
            @(negedge clk);
            #1;
            if (svalid[0] | svalid[1]) nv++;
        end
        check("midrst_no_resume", (nv == 0), 1'b1);

        // Randomized traffic
        repeat (400) begin
            @(negedge clk);
            lv = ($urandom_range(0, 3) != 0);
            ld = 8'($urandom);
        end
        @(negedge clk);
        lv = 1'b0;
        repeat (FL + 3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
